// File: rtl/cic_integ_decim.sv
// cic_integ_decim: pipelined CIC integrator chain with 1-in-R decimation.
// Rev 1.0 - initial release.
`default_nettype none

module cic_integ_decim #(
   parameter int IN_WIDTH = 8,
   parameter int WIDTH    = 20,
   parameter int N_STAGES = 3,
   parameter int R        = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_valid,
   input  logic                clear,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid
);

   localparam int              PH_W    = (R > 2) ? $clog2(R) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

   if (WIDTH < IN_WIDTH + N_STAGES * $clog2(R) || N_STAGES < 1 || R < 2) begin : g_param_check
      $error("cic_integ_decim: invalid parameter set");
   end

   logic [WIDTH-1:0] acc      [N_STAGES];
   logic [WIDTH-1:0] acc_next [N_STAGES];
   logic [PH_W-1:0]  phase;
   logic [WIDTH-1:0] in_ext;

   assign in_ext = WIDTH'($signed(in_data));

   // Each stage adds the pre-edge value of the stage before it (one-cycle pipeline per stage).
   always_comb begin
      acc_next[0] = acc[0] + in_ext;
      for (int k = 1; k < N_STAGES; k++) begin
         acc_next[k] = acc[k] + acc[k-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N_STAGES; k++) begin
            acc[k] <= '0;
         end
         phase     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < N_STAGES; k++) begin
            acc[k] <= '0;
         end
         phase     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            for (int k = 0; k < N_STAGES; k++) begin
               acc[k] <= acc_next[k];
            end
            if (phase == PH_LAST) begin
               phase     <= '0;
               out_data  <= acc_next[N_STAGES-1];
               out_valid <= 1'b1;
            end else begin
               phase <= phase + PH_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire
